// File: rtl/pwr_supervisor.sv
// pwr_supervisor
//   Power-sequencing supervisor for the ESP32 load rail. Debounces the
//   protection stage's power-good, enables the rail, holds the ESP32 in reset
//   while the rail settles, trips on sustained overcurrent with a retry
//   cooldown, and latches a fault on retry exhaustion or a blown fuse.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   powered      supply present through diode and fuse
//   fuse_blown   fuse state from the protection stage
//   current_ma   unsigned load current in mA, sampled every cycle
//   clear_fault  single-cycle request to leave LATCHED
//   load_en      load rail enable
//   esp_rst      ESP32 reset, active-high
//   pgood        rail up and load released
//   fault        high only in LATCHED
//   fault_code   last fault: 0 none, 1 overcurrent, 2 brownout, 3 fuse
//   retry_cnt    overcurrent trips since the last stable run
module pwr_supervisor #(
    parameter int DEBOUNCE_CYC   = 16,
    parameter int SETTLE_CYC     = 64,
    parameter int OC_LIMIT_MA    = 450,
    parameter int OC_TRIP_CYC    = 8,
    parameter int RETRY_WAIT_CYC = 256,
    parameter int MAX_RETRIES    = 3,
    parameter int STABLE_CYC     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        powered,
    input  logic        fuse_blown,
    input  logic [11:0] current_ma,
    input  logic        clear_fault,
    output logic        load_en,
    output logic        esp_rst,
    output logic        pgood,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [1:0]  retry_cnt
);

    localparam logic [2:0] S_OFF      = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_SETTLE   = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;
    localparam logic [2:0] S_LATCHED  = 3'd5;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OC   = 2'd1;
    localparam logic [1:0] FC_BROWN = 2'd2;
    localparam logic [1:0] FC_FUSE = 2'd3;

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int OW = $clog2(OC_TRIP_CYC + 1);
    localparam int CW = $clog2(RETRY_WAIT_CYC + 1);
    localparam int TW = $clog2(STABLE_CYC + 1);

    // Each timer counts edges spent in its state after entry; the exit fires
    // on the edge where the counter already holds N-1, so the state lasts
    // exactly N samples.
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYC - 1);
    localparam logic [OW-1:0] OC_LAST   = OW'(OC_TRIP_CYC - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(RETRY_WAIT_CYC - 1);
    localparam logic [TW-1:0] STB_LAST  = TW'(STABLE_CYC - 1);
    localparam logic [1:0]    MAX_R     = 2'(MAX_RETRIES);
    localparam logic [11:0]   OC_LIM    = 12'(OC_LIMIT_MA);

    logic [2:0]    state, state_n;
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] set_cnt;
    logic [OW-1:0] oc_cnt;
    logic [CW-1:0] cool_cnt;
    logic [TW-1:0] stable_cnt;
    logic [1:0]    fcode_n, retry_n;
    logic          over;

    assign over = (current_ma > OC_LIM);

    // Branch order inside each state encodes the priority:
    // fuse > loss of powered > overcurrent trip > timer expiry.
    always_comb begin
        state_n = state;
        fcode_n = fault_code;
        retry_n = retry_cnt;
        if (fuse_blown) begin
            state_n = S_LATCHED;
            fcode_n = FC_FUSE;
        end else begin
            case (state)
                S_OFF: begin
                    if (powered) state_n = S_DEBOUNCE;
                end
                S_DEBOUNCE: begin
                    if (!powered)                 state_n = S_OFF;
                    else if (deb_cnt == DEB_LAST) state_n = S_SETTLE;
                end
                S_SETTLE: begin
                    if (!powered) begin
                        state_n = S_OFF;
                        fcode_n = FC_BROWN;
                    end else if (set_cnt == SET_LAST) begin
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!powered) begin
                        state_n = S_OFF;
                        fcode_n = FC_BROWN;
                    end else if (over && oc_cnt == OC_LAST) begin
                        state_n = S_COOLDOWN;
                        fcode_n = FC_OC;
                        if (retry_cnt != MAX_R) retry_n = retry_cnt + 2'd1;
                    end else if (stable_cnt == STB_LAST) begin
                        retry_n = 2'd0;
                    end
                end
                S_COOLDOWN: begin
                    // Ignores powered on purpose; DEBOUNCE drops to OFF if absent.
                    if (cool_cnt == COOL_LAST)
                        state_n = (retry_cnt == MAX_R) ? S_LATCHED : S_DEBOUNCE;
                end
                S_LATCHED: begin
                    if (clear_fault) begin
                        state_n = S_OFF;
                        fcode_n = FC_NONE;
                        retry_n = 2'd0;
                    end
                end
                default: state_n = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_OFF;
            deb_cnt    <= '0;
            set_cnt    <= '0;
            oc_cnt     <= '0;
            cool_cnt   <= '0;
            stable_cnt <= '0;
            load_en    <= 1'b0;
            esp_rst    <= 1'b1;
            pgood      <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            retry_cnt  <= 2'd0;
        end else begin
            state      <= state_n;
            fault_code <= fcode_n;
            retry_cnt  <= retry_n;

            // Counters run only while the FSM stays put; any transition
            // (including entry) leaves them at zero.
            deb_cnt  <= (state == S_DEBOUNCE && state_n == S_DEBOUNCE) ? deb_cnt + 1'b1 : '0;
            set_cnt  <= (state == S_SETTLE   && state_n == S_SETTLE)   ? set_cnt + 1'b1 : '0;
            cool_cnt <= (state == S_COOLDOWN && state_n == S_COOLDOWN) ? cool_cnt + 1'b1 : '0;
            oc_cnt   <= (state == S_RUN && state_n == S_RUN && over)   ? oc_cnt + 1'b1 : '0;

            if (state == S_RUN && state_n == S_RUN) begin
                if (stable_cnt != STB_LAST) stable_cnt <= stable_cnt + 1'b1;
            end else begin
                stable_cnt <= '0;
            end

            // Outputs decode the next state so they change on the same edge
            // as the transition.
            load_en <= (state_n == S_SETTLE) || (state_n == S_RUN);
            esp_rst <= (state_n != S_RUN);
            pgood   <= (state_n == S_RUN);
            fault   <= (state_n == S_LATCHED);
        end
    end

endmodule

// File: tb/tb_pwr_supervisor.sv
// tb_pwr_supervisor
//   Directed bench for pwr_supervisor with hand-computed cycle counts using
//   the default parameters (debounce 16, settle 64, trip 8, cooldown 256).
module tb_pwr_supervisor;

    logic        clk = 1'b0;
    logic        rst;
    logic        powered;
    logic        fuse_blown;
    logic [11:0] current_ma;
    logic        clear_fault;
    logic        load_en, esp_rst, pgood, fault;
    logic [1:0]  fault_code, retry_cnt;

    int total = 0;
    int bad   = 0;

    pwr_supervisor dut (
        .clk         (clk),
        .rst         (rst),
        .powered     (powered),
        .fuse_blown  (fuse_blown),
        .current_ma  (current_ma),
        .clear_fault (clear_fault),
        .load_en     (load_en),
        .esp_rst     (esp_rst),
        .pgood       (pgood),
        .fault       (fault),
        .fault_code  (fault_code),
        .retry_cnt   (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges, landing 1ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int le, input int er,
                           input int pg, input int ft, input int fc, input int rc);
        chk({tag, ".load_en"},    int'(load_en),    le);
        chk({tag, ".esp_rst"},    int'(esp_rst),    er);
        chk({tag, ".pgood"},      int'(pgood),      pg);
        chk({tag, ".fault"},      int'(fault),      ft);
        chk({tag, ".fault_code"}, int'(fault_code), fc);
        chk({tag, ".retry_cnt"},  int'(retry_cnt),  rc);
    endtask

    initial begin
        rst = 1'b1; powered = 1'b0; fuse_blown = 1'b0;
        current_ma = 12'd120; clear_fault = 1'b0;
        step(4);
        chk_out("reset", 0, 1, 0, 0, 0, 0);

        // Clean power-up: E0 is the first edge after rst drops.
        rst = 1'b0; powered = 1'b1;
        step(16);                       // after E15
        chk("pu_E15.load_en", int'(load_en), 0);
        step(1);                        // after E16
        chk_out("pu_E16", 1, 1, 0, 0, 0, 0);
        step(63);                       // after E79
        chk("pu_E79.pgood", int'(pgood), 0);
        step(1);                        // after E80
        chk_out("pu_E80", 1, 0, 1, 0, 0, 0);

        // Threshold is strictly greater-than.
        current_ma = 12'd450;
        step(50);
        chk("oc_eq_limit.pgood", int'(pgood), 1);
        // 7 over-limit samples then back to normal: no trip.
        current_ma = 12'd480;
        step(7);
        current_ma = 12'd120;
        step(5);
        chk_out("oc_7", 1, 0, 1, 0, 0, 0);
        // 8 over-limit samples: trip on the 8th edge.
        current_ma = 12'd480;
        step(7);
        chk("oc_8_pre.load_en", int'(load_en), 1);
        current_ma = 12'd120;           // 8th sample still over: set after edge
        current_ma = 12'd480;
        step(1);
        chk_out("oc_trip", 0, 1, 0, 0, 1, 1);
        current_ma = 12'd120;
        step(255);
        chk("cool_255.load_en", int'(load_en), 0);
        step(1);                        // DEBOUNCE entered
        chk("cool_exit.load_en", int'(load_en), 0);
        step(16);
        chk("retry_settle.load_en", int'(load_en), 1);
        step(64);
        chk_out("retry_run", 1, 0, 1, 0, 1, 1);

        // Brownout on the same edge as the 8th overcurrent sample.
        current_ma = 12'd600;
        step(7);
        chk("bo_pre.pgood", int'(pgood), 1);
        powered = 1'b0;
        step(1);
        chk_out("bo_vs_oc", 0, 1, 0, 0, 2, 1);

        // Bounce: 10 good samples, one drop, then a fresh debounce.
        current_ma = 12'd120;
        powered = 1'b1;
        step(10);
        powered = 1'b0;
        step(1);
        chk_out("bounce_drop", 0, 1, 0, 0, 2, 1);
        powered = 1'b1;
        step(1);                        // final rising sample F0
        step(15);
        chk("bounce_F15.load_en", int'(load_en), 0);
        step(64);                       // after F79
        chk("bounce_F79.pgood", int'(pgood), 0);
        step(1);                        // after F80
        chk_out("bounce_F80", 1, 0, 1, 0, 2, 1);
        // clear_fault outside LATCHED does nothing.
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk_out("clr_in_run", 1, 0, 1, 0, 2, 1);

        // Mid-operation reset.
        rst = 1'b1;
        step(1);
        chk_out("rst_mid", 0, 1, 0, 0, 0, 0);

        // Retry exhaustion with current held high from the start.
        // Trips at E88, E432, E776; LATCHED at E1032.
        current_ma = 12'd2000;
        rst = 1'b0;
        step(501);                      // after E500, second cooldown
        chk("exh_E500.retry_cnt", int'(retry_cnt), 2);
        chk("exh_E500.load_en", int'(load_en), 0);
        step(531);                      // after E1031
        chk("exh_E1031.fault", int'(fault), 0);
        step(1);                        // after E1032
        chk_out("exh_latched", 0, 1, 0, 1, 1, 3);
        current_ma = 12'd120;
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk_out("exh_cleared", 0, 1, 0, 0, 0, 0);

        // Fuse during RUN, then clear attempts.
        step(81);                       // E0..E80 after the OFF edge
        chk("fuse_pre.pgood", int'(pgood), 1);
        fuse_blown = 1'b1;
        step(1);
        chk_out("fuse_trip", 0, 1, 0, 1, 3, 0);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk_out("fuse_clr_ignored", 0, 1, 0, 1, 3, 0);
        fuse_blown = 1'b0;
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk_out("fuse_clr_ok", 0, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
